// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor
//   Watches a 16-lamp flasher and checks that its lit-lamp count follows the
//   expected up/down pattern:
//     0 -> 16 -> 5 -> 11 -> 0 -> 6 -> 0
//   The flick input can kick the sequence back at two of the turning points.
//   Two kinds of fault are detected and latched:
//     - err_step : the level changed by anything other than the required +1/-1
//     - err_shape: the lamp vector is not thermometer coded
//   Every output is registered, so outputs reflect the lamp vector one cycle later.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   lamp      flasher lamp vector; bit 0 is the first lamp lit
//   flk       flick request, sampled together with lamp
//   err_clr   clears err_step, err_shape and err_cnt
//   phase     decoded flasher phase (0 = idle, 1..6 = sequence legs)
//   level     number of lit lamps seen on the previous cycle
//   done      one-cycle pulse when a full sequence completes
//   err_step  sticky flag for an illegal level step
//   err_shape sticky flag for a non-thermometer lamp vector
//   err_cnt   saturating count of error cycles
module lamp_sequence_monitor #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          lamp,
  input  logic                 flk,
  input  logic                 err_clr,
  output logic [2:0]           phase,
  output logic [4:0]           level,
  output logic                 done,
  output logic                 err_step,
  output logic                 err_shape,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP_A = 3'd1,
    DN_B = 3'd2,
    UP_C = 3'd3,
    DN_D = 3'd4,
    UP_E = 3'd5,
    DN_F = 3'd6
  } state_t;

  state_t               st;
  state_t               nxt;
  logic [4:0]           n;
  logic                 shape_bad;
  logic                 step_bad;
  logic                 fin;
  logic [ERR_CNT_W-1:0] cnt_inc;

  assign phase = st;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + 5'(lamp[i]);
    end
  end

  // A thermometer code has all set bits contiguous from bit 0, so adding one
  // carries through every set bit and leaves no overlap with the original.
  assign shape_bad = (lamp & (lamp + 16'd1)) != 16'd0;

  assign cnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);

  always_comb begin
    nxt      = st;
    step_bad = 1'b0;
    fin      = 1'b0;
    case (st)
      IDLE: nxt = (level == 5'd0 && n == 5'd1) ? UP_A : IDLE;
      UP_A: begin
        if (n != level + 5'd1)  step_bad = 1'b1;
        else if (n == 5'd16)    nxt = DN_B;
      end
      DN_B: begin
        if (n != level - 5'd1)  step_bad = 1'b1;
        else if (n == 5'd5)     nxt = flk ? UP_A : UP_C;
      end
      UP_C: begin
        if (n != level + 5'd1)  step_bad = 1'b1;
        else if (n == 5'd11)    nxt = DN_D;
      end
      DN_D: begin
        if (n != level - 5'd1)          step_bad = 1'b1;
        else if (n == 5'd0)             nxt = flk ? UP_C : UP_E;
        else if (n == 5'd5 && flk)      nxt = UP_C;
      end
      UP_E: begin
        if (n != level + 5'd1)  step_bad = 1'b1;
        else if (n == 5'd6)     nxt = DN_F;
      end
      DN_F: begin
        if (n != level - 5'd1)  step_bad = 1'b1;
        else if (n == 5'd0) begin
          nxt = IDLE;
          fin = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      level     <= '0;
      done      <= 1'b0;
      err_step  <= 1'b0;
      err_shape <= 1'b0;
      err_cnt   <= '0;
    end else begin
      level <= n;
      done  <= 1'b0;
      if (err_clr) begin
        err_step  <= 1'b0;
        err_shape <= 1'b0;
        err_cnt   <= '0;
      end
      // Later assignments override the clear so a same-cycle error wins.
      if (shape_bad) begin
        st        <= IDLE;
        err_shape <= 1'b1;
        err_cnt   <= err_clr ? ERR_CNT_W'(1) : cnt_inc;
      end else if (step_bad) begin
        st        <= IDLE;
        err_step  <= 1'b1;
        err_cnt   <= err_clr ? ERR_CNT_W'(1) : cnt_inc;
      end else begin
        st   <= nxt;
        done <= fin;
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
module tb_lamp_sequence_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lamp;
  logic        flk;
  logic        err_clr;

  logic [2:0]  phase8, phase2;
  logic [4:0]  level8, level2;
  logic        done8, done2, es8, es2, esh8, esh2;
  logic [7:0]  cnt8;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  lamp_sequence_monitor #(.ERR_CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .lamp(lamp), .flk(flk), .err_clr(err_clr),
    .phase(phase8), .level(level8), .done(done8),
    .err_step(es8), .err_shape(esh8), .err_cnt(cnt8)
  );

  lamp_sequence_monitor #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .lamp(lamp), .flk(flk), .err_clr(err_clr),
    .phase(phase2), .level(level2), .done(done2),
    .err_step(es2), .err_shape(esh2), .err_cnt(cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  // Reference model state
  int m_ph, m_lv, m_done, m_es, m_esh, m_c8, m_c2;

  // Turning points of the sequence: at phase ph, reaching level lv with the
  // given flick (-1 = don't care) moves to phase nx.
  typedef struct { int ph; int lv; int fk; int nx; } turn_t;
  turn_t turns [9];

  typedef struct {
    logic [15:0] lamp;
    logic        flk, clr, rst;
    int          ph, lv, dn, es, esh, cnt;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [15:0] therm(input int k);
    logic [16:0] t;
    t = (17'd1 << k) - 17'd1;
    return t[15:0];
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [15:0] l, input logic f, input logic c, input logic r);
    int  k, nx, want;
    bit  shp, stp;
    k = $countones(l);
    if (r) begin
      m_ph = 0; m_lv = 0; m_done = 0; m_es = 0; m_esh = 0; m_c8 = 0; m_c2 = 0;
      return;
    end
    shp = (l != therm(k));
    stp = 1'b0;
    nx = m_ph;
    m_done = 0;
    if (shp) nx = 0;
    else if (m_ph == 0) nx = (m_lv == 0 && k == 1) ? 1 : 0;
    else begin
      want = (m_ph % 2 == 1) ? m_lv + 1 : m_lv - 1;
      if (k != want) begin
        stp = 1'b1;
        nx = 0;
      end else begin
        foreach (turns[i])
          if (turns[i].ph == m_ph && turns[i].lv == k && (turns[i].fk < 0 || turns[i].fk == int'(f))) begin
            nx = turns[i].nx;
            if (m_ph == 6) m_done = 1;
          end
      end
    end
    if (c) begin m_es = 0; m_esh = 0; m_c8 = 0; m_c2 = 0; end
    if (shp) m_esh = 1;
    else if (stp) m_es = 1;
    if (shp || stp) begin
      m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
      m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
    end
    m_lv = k;
    m_ph = nx;
  endtask

  task automatic step(input logic [15:0] l, input logic f, input logic c, input logic r);
    lamp = l; flk = f; err_clr = c; rst = r;
    model_step(l, f, c, r);
    @(posedge clk);
    #1;
    if (done8) n_done++;
    check("phase",     int'(phase8), m_ph);
    check("level",     int'(level8), m_lv);
    check("done",      int'(done8),  m_done);
    check("err_step",  int'(es8),    m_es);
    check("err_shape", int'(esh8),   m_esh);
    check("err_cnt",   int'(cnt8),   m_c8);
    check("phase_w2",  int'(phase2), m_ph);
    check("err_cnt_w2", int'(cnt2),  m_c2);
  endtask

  // Walk the level one lamp at a time to tgt with flk=0.
  task automatic walk(input int tgt);
    while (m_lv != tgt) begin
      if (tgt > m_lv) step(therm(m_lv + 1), 1'b0, 1'b0, 1'b0);
      else            step(therm(m_lv - 1), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int nn, r;
    logic [15:0] l;

    turns[0] = '{1, 16, -1, 2};
    turns[1] = '{2,  5,  1, 1};
    turns[2] = '{2,  5,  0, 3};
    turns[3] = '{3, 11, -1, 4};
    turns[4] = '{4,  5,  1, 3};
    turns[5] = '{4,  0,  1, 3};
    turns[6] = '{4,  0,  0, 5};
    turns[7] = '{5,  6, -1, 6};
    turns[8] = '{6,  0, -1, 0};

    //           lamp      flk   clr   rst   ph lv dn es esh cnt
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{16'h0003, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 0, 0};
    vecs[2]  = '{16'h0001, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{16'h0001, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0};
    vecs[5]  = '{16'h0003, 1'b0, 1'b0, 1'b0, 1, 2, 0, 0, 0, 0};
    vecs[6]  = '{16'h0007, 1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0, 0};
    vecs[7]  = '{16'h000F, 1'b0, 1'b0, 1'b0, 1, 4, 0, 0, 0, 0};
    vecs[8]  = '{16'h0005, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 1, 1};
    vecs[9]  = '{16'h0005, 1'b0, 1'b1, 1'b0, 0, 2, 0, 0, 1, 1};
    vecs[10] = '{16'h0003, 1'b0, 1'b1, 1'b0, 0, 2, 0, 0, 0, 0};
    vecs[11] = '{16'h0006, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 1, 1};
    vecs[12] = '{16'h0000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{16'h0001, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0};
    vecs[14] = '{16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0, 1};
    vecs[15] = '{16'h0001, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};

    m_ph = 0; m_lv = 0; m_done = 0; m_es = 0; m_esh = 0; m_c8 = 0; m_c2 = 0;
    lamp = '0; flk = 1'b0; err_clr = 1'b0; rst = 1'b1;

    // Reset state
    do_reset();
    do_reset();

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].lamp, vecs[i].flk, vecs[i].clr, vecs[i].rst);
      check("vec_phase",  int'(phase8), vecs[i].ph);
      check("vec_level",  int'(level8), vecs[i].lv);
      check("vec_done",   int'(done8),  vecs[i].dn);
      check("vec_step",   int'(es8),    vecs[i].es);
      check("vec_shape",  int'(esh8),   vecs[i].esh);
      check("vec_cnt",    int'(cnt8),   vecs[i].cnt);
    end

    // Clean run
    do_reset();
    n_done = 0;
    walk(16); check("clean_ph_b", int'(phase8), 2);
    walk(5);  check("clean_ph_c", int'(phase8), 3);
    walk(11); check("clean_ph_d", int'(phase8), 4);
    walk(0);  check("clean_ph_e", int'(phase8), 5);
    walk(6);  check("clean_ph_f", int'(phase8), 6);
    walk(0);  check("clean_ph_end", int'(phase8), 0);
    check("clean_done", int'(done8), 1);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    check("clean_done_pulse", int'(done8), 0);
    check("clean_done_count", n_done, 1);
    check("clean_errs", int'(es8) + int'(esh8) + int'(cnt8), 0);

    // Kickback in DN_B
    do_reset();
    n_done = 0;
    walk(16); walk(6);
    step(therm(5), 1'b1, 1'b0, 1'b0);
    check("kickb_ph", int'(phase8), 1);
    step(therm(6), 1'b0, 1'b0, 1'b0);
    check("kickb_up", int'(phase8), 1);
    check("kickb_noerr", int'(es8), 0);
    walk(16); walk(5); walk(11); walk(0); walk(6); walk(0);
    check("kickb_done_count", n_done, 1);

    // Kickbacks in DN_D
    do_reset();
    walk(16); walk(5); walk(11); walk(6);
    step(therm(5), 1'b1, 1'b0, 1'b0);
    check("kickd5_ph", int'(phase8), 3);
    walk(11); walk(1);
    step(therm(0), 1'b1, 1'b0, 1'b0);
    check("kickd0_ph", int'(phase8), 3);
    step(therm(1), 1'b0, 1'b0, 1'b0);
    check("kickd0_up", int'(phase8), 3);
    check("kickd0_lvl", int'(level8), 1);
    check("kickd0_noerr", int'(es8) + int'(esh8), 0);

    // Step fault in UP_A
    do_reset();
    walk(7);
    step(therm(9), 1'b0, 1'b0, 1'b0);
    check("stepf_flag", int'(es8), 1);
    check("stepf_cnt",  int'(cnt8), 1);
    check("stepf_ph",   int'(phase8), 0);
    check("stepf_lvl",  int'(level8), 9);
    check("stepf_done", int'(done8), 0);

    // Shape fault in UP_C, then clear
    do_reset();
    walk(16); walk(5); walk(8);
    step(16'h0005, 1'b0, 1'b0, 1'b0);
    check("shapef_flag", int'(esh8), 1);
    check("shapef_step", int'(es8), 0);
    check("shapef_ph",   int'(phase8), 0);
    check("shapef_lvl",  int'(level8), 2);
    step(16'h0003, 1'b0, 1'b1, 1'b0);
    check("shapef_clr", int'(esh8) + int'(es8) + int'(cnt8), 0);

    // Saturation in the 2-bit counter, then reset mid-UP_C
    do_reset();
    for (int i = 0; i < 4; i++) step(16'h0005, 1'b0, 1'b0, 1'b0);
    check("sat_w2", int'(cnt2), 3);
    check("sat_w8", int'(cnt8), 4);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    walk(16); walk(5); walk(7);
    step(therm(8), 1'b0, 1'b0, 1'b1);
    check("rst_all", int'(phase8) + int'(level8) + int'(done8) + int'(es8) + int'(esh8) + int'(cnt2), 0);
    step(therm(2), 1'b0, 1'b0, 1'b0);
    check("rst_resume_ph", int'(phase8), 0);
    check("rst_resume_err", int'(es8), 0);

    // Randomized walk against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 82) begin
        if (m_ph == 0) nn = (m_lv == 0) ? 1 : 0;
        else nn = (m_ph % 2 == 1) ? m_lv + 1 : m_lv - 1;
        if (nn < 0) nn = 0;
        if (nn > 16) nn = 16;
        l = therm(nn);
      end else if (r < 90) begin
        l = therm($urandom_range(0, 16));
      end else begin
        l = 16'($urandom);
      end
      step(l, ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
